ex_mem: RTL
===========

# ex_mem

Execute stage plus EX/MEM pipeline latch of the 5-stage MIPS core. Takes decoded operands and control buses from ID/EX, computes the ALU result, branch target and zero flag, and registers everything the MEM_WB stage consumes. Hosts a sequential unsigned multiply/divide unit with HI/LO registers that stalls the front of the pipeline while busy.

## Interface
- len_data, 32, datapath width
- num_bits, 5, register-index width
- len_mem_bus, 9, memory control bus width (passed through)
- len_wb_bus, 2, write-back control bus width (passed through)
- len_alu_ctrl, 4, ALU control width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_data_a  in  len_data  rs operand
- in_data_b  in  len_data  rt operand
- in_imm  in  len_data  sign-extended immediate
- alu_src  in  1  1: operand B = in_imm, 0: in_data_b
- in_shamt  in  5  shift amount
- alu_ctrl  in  len_alu_ctrl  operation code
- in_pc_next  in  len_data  PC+4 of this instruction
- in_memory_bus, in_writeBack_bus, in_write_reg, in_halt_flag  in  widths per parameters / 1  control to forward
- flush  in  1  synchronous: replace this stage's instruction with a bubble
- out_addr_mem, out_write_data, out_pc_branch  out  len_data  registered ALU result, in_data_b, branch target
- out_memory_bus, out_writeBack_bus, out_write_reg  out  per parameters  registered control
- out_zero_flag, out_halt_flag_m  out  1  registered
- stall  out  1  combinational; holds PC, IF/ID and ID/EX

## Operation
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA (operand B by in_shamt), 11 LUI (in_imm[15:0]<<16), 12 MULTU, 13 DIVU, 14 MFHI, 15 MFLO.
- All arithmetic modulo 2^32, no overflow trap; zero_flag = (result == 0); branch target = in_pc_next + (in_imm << 2), truncated to len_data.
- MULTU/DIVU write only HI/LO; their latched entry carries the incoming buses unchanged (decoder supplies no GPR write, no memory access).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: MULTU/DIVU present and no flush → capture operands, count=0, go BUSY; stall=1, latch loads bubble. Otherwise latch normal, stall=0.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle; stall=1, bubble; after count=31 go DONE and write HI/LO (MULTU: HI=product[63:32], LO=product[31:0]; DIVU: HI=remainder, LO=quotient).
  - DONE: stall=0, held instruction latched normally, go IDLE.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend; no exception.
- Bubble: out_memory_bus, out_writeBack_bus, out_write_reg, out_halt_flag_m, out_zero_flag = 0; datapath outputs don't-care (implemented as hold).
- flush in any state: bubble latched, FSM to IDLE, HI/LO unchanged, stall=0 that cycle.

## Timing
- Normal ops: 1-cycle latency, inputs at edge N visible on outputs after edge N.
- MULTU/DIVU: stall high for 33 consecutive cycles (IDLE entry cycle + 32 BUSY); instruction registered on the 34th edge.
- MFHI/MFLO immediately after MULTU/DIVU reads the new value (HI/LO written on BUSY→DONE edge).
- reset low (any time, incl. mid-BUSY): all outputs 0, HI/LO 0, count 0, FSM IDLE, stall 0.

## Configuration
- EX_MEM_MULDIV_EN defined: FSM, HI/LO and codes 12-15 as above.
- Not defined: no FSM or HI/LO; codes 12-15 give result 0 with buses passed through; stall tied 0.

## Structure
- Shared header/package: ALU control code constants, FSM state encodings, bus widths.
- One sub-module: muldiv_seq (FSM, counter, HI/LO, start/flush/busy/done), instantiated under EX_MEM_MULDIV_EN.

## Test plan
- ADD a=7, b=-3 → out_addr_mem=4, zero=0; SUB a=b=5 → zero=1.
- alu_src=1, in_imm=-1, in_pc_next=0x100 → out_pc_branch=0xFC.
- MULTU 0xFFFFFFFF×2 → stall 33 cycles, then MFHI=1, MFLO=0xFFFFFFFE.
- DIVU 100/7 → LO=14, HI=2; DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- flush at BUSY count=10 → stall drops same cycle, FSM IDLE, HI/LO keep previous values.
- reset low at BUSY count=20 → all outputs 0, stall 0; next MFLO returns 0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants for the execute stage: ALU codes, mul/div FSM states, bus widths.
// The optional sequential mul/div unit is enabled with the EX_MEM_MULDIV_EN macro.
package ex_mem_pkg;

  localparam int LEN_DATA     = 32;
  localparam int NUM_BITS     = 5;
  localparam int LEN_MEM_BUS  = 9;
  localparam int LEN_WB_BUS   = 2;
  localparam int LEN_ALU_CTRL = 4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_LUI   = 4'd11;
  localparam logic [3:0] ALU_MULTU = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_MFHI  = 4'd14;
  localparam logic [3:0] ALU_MFLO  = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_muldiv_op(input logic [3:0] code);
    return (code == ALU_MULTU) || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_mem_muldiv_seq.sv
// Sequential unsigned multiply/divide: one shift-add or restoring-subtract step per
// cycle over a shared {HI,LO}-shaped accumulator, writing HI/LO when the last step retires.
module muldiv_seq
  import ex_mem_pkg::*;
#(
  parameter int len_data = LEN_DATA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_req,
  input  logic                flush,
  input  logic                is_div,
  input  logic [len_data-1:0] op_a,
  input  logic [len_data-1:0] op_b,
  output logic                stall,
  output logic [len_data-1:0] hi,
  output logic [len_data-1:0] lo
);

  localparam int CNT_W = $clog2(len_data);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(len_data - 1);

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      count_r;
  logic                  div_r;
  logic [len_data-1:0]   operand_r;
  logic [2*len_data-1:0] acc_r;
  logic [2*len_data-1:0] acc_next_s;
  logic [len_data:0]     sum_s;
  logic [len_data:0]     diff_s;
  logic [len_data-1:0]   hi_r;
  logic [len_data-1:0]   lo_r;

  // Next accumulator value for one multiply or divide step.
  always_comb begin
    sum_s      = {(len_data+1){1'b0}};
    diff_s     = {(len_data+1){1'b0}};
    acc_next_s = acc_r;
    if (div_r) begin
      // Upper half is the partial remainder; a borrow means the trial subtract is undone.
      diff_s = acc_r[2*len_data-1:len_data-1] - {1'b0, operand_r};
      if (!diff_s[len_data]) begin
        acc_next_s = {diff_s[len_data-1:0], acc_r[len_data-2:0], 1'b1};
      end else begin
        acc_next_s = {acc_r[2*len_data-2:0], 1'b0};
      end
    end else begin
      sum_s      = {1'b0, acc_r[2*len_data-1:len_data]} +
                   (acc_r[0] ? {1'b0, operand_r} : {(len_data+1){1'b0}});
      acc_next_s = {sum_s, acc_r[len_data-1:1]};
    end
  end

  // Front-of-pipe stall: entry cycle and every busy cycle, never while flushing.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      ST_IDLE: stall = start_req & ~flush;
      ST_BUSY: stall = ~flush;
      default: stall = 1'b0;
    endcase
  end

  // FSM, step counter, operand capture and HI/LO update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      count_r   <= {CNT_W{1'b0}};
      div_r     <= 1'b0;
      operand_r <= {len_data{1'b0}};
      acc_r     <= {(2*len_data){1'b0}};
      hi_r      <= {len_data{1'b0}};
      lo_r      <= {len_data{1'b0}};
    end else if (flush) begin
      state_r <= ST_IDLE;
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_req) begin
            state_r   <= ST_BUSY;
            count_r   <= {CNT_W{1'b0}};
            div_r     <= is_div;
            operand_r <= op_b;
            acc_r     <= {{len_data{1'b0}}, op_a};
          end
        end
        ST_BUSY: begin
          acc_r   <= acc_next_s;
          count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (count_r == LAST_STEP) begin
            state_r <= ST_DONE;
            hi_r    <= acc_next_s[2*len_data-1:len_data];
            lo_r    <= acc_next_s[len_data-1:0];
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/ex_mem.sv
// Execute stage and EX/MEM latch: ALU, branch target, zero flag, registered control.
// Define EX_MEM_MULDIV_EN to add the stalling MULTU/DIVU unit with HI/LO.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int len_data     = LEN_DATA,
  parameter int num_bits     = NUM_BITS,
  parameter int len_mem_bus  = LEN_MEM_BUS,
  parameter int len_wb_bus   = LEN_WB_BUS,
  parameter int len_alu_ctrl = LEN_ALU_CTRL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [len_data-1:0]     in_data_a,
  input  logic [len_data-1:0]     in_data_b,
  input  logic [len_data-1:0]     in_imm,
  input  logic                    alu_src,
  input  logic [4:0]              in_shamt,
  input  logic [len_alu_ctrl-1:0] alu_ctrl,
  input  logic [len_data-1:0]     in_pc_next,
  input  logic [len_mem_bus-1:0]  in_memory_bus,
  input  logic [len_wb_bus-1:0]   in_writeBack_bus,
  input  logic [num_bits-1:0]     in_write_reg,
  input  logic                    in_halt_flag,
  input  logic                    flush,
  output logic [len_data-1:0]     out_addr_mem,
  output logic [len_data-1:0]     out_write_data,
  output logic [len_data-1:0]     out_pc_branch,
  output logic [len_mem_bus-1:0]  out_memory_bus,
  output logic [len_wb_bus-1:0]   out_writeBack_bus,
  output logic [num_bits-1:0]     out_write_reg,
  output logic                    out_zero_flag,
  output logic                    out_halt_flag_m,
  output logic                    stall
);

  logic [len_data-1:0] op_b_s;
  logic [len_data-1:0] alu_res_s;
  logic [len_data-1:0] hi_s;
  logic [len_data-1:0] lo_s;
  logic                stall_s;
  logic                bubble_s;

`ifdef EX_MEM_MULDIV_EN
  muldiv_seq #(.len_data(len_data)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start_req (is_muldiv_op(alu_ctrl)),
    .flush     (flush),
    .is_div    (alu_ctrl == ALU_DIVU),
    .op_a      (in_data_a),
    .op_b      (in_data_b),
    .stall     (stall_s),
    .hi        (hi_s),
    .lo        (lo_s)
  );
`else
  assign stall_s = 1'b0;
  assign hi_s    = {len_data{1'b0}};
  assign lo_s    = {len_data{1'b0}};
`endif

  assign stall    = stall_s;
  assign bubble_s = flush | stall_s;

  // ALU; MULTU/DIVU produce no GPR result.
  always_comb begin
    op_b_s    = alu_src ? in_imm : in_data_b;
    alu_res_s = {len_data{1'b0}};
    case (alu_ctrl)
      ALU_ADD:  alu_res_s = in_data_a + op_b_s;
      ALU_SUB:  alu_res_s = in_data_a - op_b_s;
      ALU_AND:  alu_res_s = in_data_a & op_b_s;
      ALU_OR:   alu_res_s = in_data_a | op_b_s;
      ALU_XOR:  alu_res_s = in_data_a ^ op_b_s;
      ALU_NOR:  alu_res_s = ~(in_data_a | op_b_s);
      ALU_SLT:  alu_res_s = {{(len_data-1){1'b0}}, ($signed(in_data_a) < $signed(op_b_s))};
      ALU_SLTU: alu_res_s = {{(len_data-1){1'b0}}, (in_data_a < op_b_s)};
      ALU_SLL:  alu_res_s = op_b_s << in_shamt;
      ALU_SRL:  alu_res_s = op_b_s >> in_shamt;
      ALU_SRA:  alu_res_s = $signed(op_b_s) >>> in_shamt;
      ALU_LUI:  alu_res_s = {in_imm[15:0], 16'h0000};
      ALU_MFHI: alu_res_s = hi_s;
      ALU_MFLO: alu_res_s = lo_s;
      default:  alu_res_s = {len_data{1'b0}};
    endcase
  end

  // EX/MEM latch; a bubble clears control and holds the datapath fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_addr_mem      <= {len_data{1'b0}};
      out_write_data    <= {len_data{1'b0}};
      out_pc_branch     <= {len_data{1'b0}};
      out_memory_bus    <= {len_mem_bus{1'b0}};
      out_writeBack_bus <= {len_wb_bus{1'b0}};
      out_write_reg     <= {num_bits{1'b0}};
      out_zero_flag     <= 1'b0;
      out_halt_flag_m   <= 1'b0;
    end else if (bubble_s) begin
      out_memory_bus    <= {len_mem_bus{1'b0}};
      out_writeBack_bus <= {len_wb_bus{1'b0}};
      out_write_reg     <= {num_bits{1'b0}};
      out_zero_flag     <= 1'b0;
      out_halt_flag_m   <= 1'b0;
    end else begin
      out_addr_mem      <= alu_res_s;
      out_write_data    <= in_data_b;
      out_pc_branch     <= in_pc_next + (in_imm << 2);
      out_memory_bus    <= in_memory_bus;
      out_writeBack_bus <= in_writeBack_bus;
      out_write_reg     <= in_write_reg;
      out_zero_flag     <= (alu_res_s == {len_data{1'b0}});
      out_halt_flag_m   <= in_halt_flag;
    end
  end

endmodule
